// File: rtl/mux_scan_ctrl_pkg.sv
// Shared types and sizes for the 4:1 mux scan sequencer.
// State encodings are fixed so the values are stable for anyone decoding them.
package mux_scan_ctrl_pkg;

    localparam int NCH   = 4;
    localparam int SEL_W = 2;
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_HOLD    = 2'd3
    } scan_state_e;

endpackage

// File: rtl/mux_scan_ctrl_next_ch_pick.sv
// Finds the lowest enabled channel strictly above cur,
// or the lowest enabled channel overall when from_start is set.
module next_ch_pick
    import mux_scan_ctrl_pkg::*;
(
    input  logic [NCH-1:0]   mask,
    input  logic [SEL_W-1:0] cur,
    input  logic             from_start,
    output logic [SEL_W-1:0] next_ch,
    output logic             none_left
);

    logic [NCH-1:0] cand;
    genvar gi;

    generate
        for (gi = 0; gi < NCH; gi++) begin : g_cand
            assign cand[gi] = mask[gi] && (from_start || (SEL_W'(gi) > cur));
        end
    endgenerate

    // Descending walk so the lowest candidate wins.
    always_comb begin
        next_ch   = '0;
        none_left = 1'b1;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (cand[i]) begin
                next_ch   = SEL_W'(i);
                none_left = 1'b0;
            end
        end
    end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Scans the enabled inputs of a 4:1 mux in ascending order, samples each after
// a settle delay, and hands the assembled word out over valid/ready.
module mux_scan_ctrl
    import mux_scan_ctrl_pkg::*;
#(
    parameter int SETTLE     = 1,
    parameter bit CONTINUOUS = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [NCH-1:0]   ch_mask,
    output logic [SEL_W-1:0] select,
    input  logic             mux_out,
    output logic [NCH-1:0]   sample,
    output logic             valid,
    input  logic             ready,
    output logic             busy
);

    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE - 1);

    scan_state_e      state_reg, state_next;
    logic [SEL_W-1:0] sel_reg, sel_next;
    logic [NCH-1:0]   sample_reg, sample_next;
    logic [NCH-1:0]   mask_reg, mask_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;

    logic [NCH-1:0]   pick_mask;
    logic             pick_from_start;
    logic [SEL_W-1:0] pick_ch;
    logic             pick_none;

    // In IDLE the mask is not latched yet, so search the live input.
    assign pick_mask       = (state_reg == ST_IDLE) ? ch_mask : mask_reg;
    assign pick_from_start = (state_reg != ST_CAPTURE);

    next_ch_pick u_pick (
        .mask       (pick_mask),
        .cur        (sel_reg),
        .from_start (pick_from_start),
        .next_ch    (pick_ch),
        .none_left  (pick_none)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= ST_IDLE;
            sel_reg    <= '0;
            sample_reg <= '0;
            mask_reg   <= '0;
            cnt_reg    <= '0;
        end else begin
            state_reg  <= state_next;
            sel_reg    <= sel_next;
            sample_reg <= sample_next;
            mask_reg   <= mask_next;
            cnt_reg    <= cnt_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        sel_next    = sel_reg;
        sample_next = sample_reg;
        mask_next   = mask_reg;
        cnt_next    = cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                sel_next = '0;
                if (start) begin
                    mask_next   = ch_mask;
                    sample_next = '0;
                    if (pick_none) begin
                        state_next = ST_HOLD;
                    end else begin
                        state_next = ST_SETTLE;
                        sel_next   = pick_ch;
                        cnt_next   = SETTLE_LOAD;
                    end
                end
            end
            ST_SETTLE: begin
                if (cnt_reg == '0) begin
                    state_next = ST_CAPTURE;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            ST_CAPTURE: begin
                sample_next[sel_reg] = mux_out;
                if (pick_none) begin
                    state_next = ST_HOLD;
                end else begin
                    state_next = ST_SETTLE;
                    sel_next   = pick_ch;
                    cnt_next   = SETTLE_LOAD;
                end
            end
            ST_HOLD: begin
                if (ready) begin
                    if (CONTINUOUS) begin
                        // An empty latched mask just re-presents a zero word.
                        sample_next = '0;
                        if (!pick_none) begin
                            state_next = ST_SETTLE;
                            sel_next   = pick_ch;
                            cnt_next   = SETTLE_LOAD;
                        end
                    end else begin
                        state_next = ST_IDLE;
                        sel_next   = '0;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign select = sel_reg;
    assign sample = sample_reg;
    assign valid  = (state_reg == ST_HOLD);
    assign busy   = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed plus randomized bench for mux_scan_ctrl; expected values come from
// the scan rules (mask order, SETTLE+1 cycles per channel, sample = D & mask).
module tb_mux_scan_ctrl;

    localparam int S  = 1;
    localparam int SC = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       start = 1'b0;
    logic [3:0] ch_mask = 4'h0;
    logic       ready = 1'b0;
    logic [3:0] d_in = 4'h0;
    logic       mux_out;
    logic [1:0] select;
    logic [3:0] sample;
    logic       valid;
    logic       busy;

    logic       start_c = 1'b0;
    logic [3:0] ch_mask_c = 4'h0;
    logic       ready_c = 1'b0;
    logic [3:0] d_c = 4'h0;
    logic       mux_out_c;
    logic [1:0] select_c;
    logic [3:0] sample_c;
    logic       valid_c;
    logic       busy_c;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Behavioural 4:1 muxes feeding the controllers.
    assign mux_out   = d_in[select];
    assign mux_out_c = d_c[select_c];

    mux_scan_ctrl #(.SETTLE(S), .CONTINUOUS(1'b0)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .ch_mask (ch_mask),
        .select  (select),
        .mux_out (mux_out),
        .sample  (sample),
        .valid   (valid),
        .ready   (ready),
        .busy    (busy)
    );

    mux_scan_ctrl #(.SETTLE(SC), .CONTINUOUS(1'b1)) dut_c (
        .clk     (clk),
        .rst     (rst),
        .start   (start_c),
        .ch_mask (ch_mask_c),
        .select  (select_c),
        .mux_out (mux_out_c),
        .sample  (sample_c),
        .valid   (valid_c),
        .ready   (ready_c),
        .busy    (busy_c)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full transaction on dut: scan, optional stall, handshake, back to IDLE.
    task automatic run_scan(input logic [3:0] m, input logic [3:0] d, input int hold);
        logic [3:0] exp_s;
        int         exp_sel;
        int         cyc;
        exp_s   = d & m;
        exp_sel = 0;
        for (int ch = 0; ch < 4; ch++) if (m[ch]) exp_sel = ch;
        cyc     = 0;
        ready   = (hold == 0);
        start   = 1'b1;
        ch_mask = m;
        d_in    = d;
        @(negedge clk);
        start = 1'b0;
        for (int ch = 0; ch < 4; ch++) begin
            if (m[ch]) begin
                for (int k = 0; k < S + 1; k++) begin
                    check("scan_select", select, ch);
                    check("scan_valid", valid, 0);
                    check("scan_busy", busy, 1);
                    start   = 1'($urandom_range(0, 1));
                    ch_mask = 4'($urandom);
                    cyc++;
                    @(negedge clk);
                end
            end
        end
        start = 1'b0;
        check("valid_rise", valid, 1);
        check("sample_word", sample, exp_s);
        check("hold_select", select, exp_sel);
        check("hold_busy", busy, 1);
        for (int h = 0; h < hold; h++) begin
            d_in    = 4'($urandom);
            ch_mask = 4'($urandom);
            @(negedge clk);
            check("stall_valid", valid, 1);
            check("stall_sample", sample, exp_s);
            check("stall_select", select, exp_sel);
        end
        ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ready = 1'b0;
        check("hs_valid", valid, 0);
        check("hs_busy", busy, 0);
        check("hs_select", select, 0);
        @(negedge clk);
        check("hs_start_ignored", busy, 0);
        $display("scan mask=%b d=%b hold=%0d cycles=%0d sample=%b", m, d, hold, cyc, sample);
    endtask

    initial begin
        // Reset state.
        @(negedge clk);
        @(negedge clk);
        check("rst_select", select, 0);
        check("rst_sample", sample, 0);
        check("rst_valid", valid, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        @(negedge clk);

        // Reset in the middle of a scan, after ch0 was already captured.
        start   = 1'b1;
        ch_mask = 4'hF;
        d_in    = 4'hF;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("mid_sample_partial", sample, 4'b0001);
        check("mid_select", select, 1);
        rst = 1'b1;
        #1;
        check("arst_select", select, 0);
        check("arst_sample", sample, 0);
        check("arst_valid", valid, 0);
        check("arst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("post_rst_valid", valid, 0);
            check("post_rst_busy", busy, 0);
        end
        $display("reset mid-scan done");

        // Directed transactions.
        run_scan(4'hF, 4'b1010, 0);
        run_scan(4'b0101, 4'hF, 0);
        run_scan(4'h0, 4'hF, 0);
        run_scan(4'b1101, 4'b0110, 10);

        // Randomized transactions.
        for (int t = 0; t < 8; t++) begin
            run_scan(4'($urandom), 4'($urandom), $urandom_range(0, 3));
        end

        // Continuous rescan on the second instance.
        start_c   = 1'b1;
        ch_mask_c = 4'b1000;
        d_c       = 4'($urandom);
        @(negedge clk);
        start_c   = 1'b0;
        ch_mask_c = 4'h0;
        ready_c   = 1'b1;
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < SC + 1; k++) begin
                check("cont_select", select_c, 3);
                check("cont_valid", valid_c, 0);
                check("cont_busy", busy_c, 1);
                @(negedge clk);
            end
            check("cont_valid_rise", valid_c, 1);
            check("cont_sample", sample_c, d_c & 4'b1000);
            check("cont_busy_hold", busy_c, 1);
            $display("continuous round %0d d=%b sample=%b", r, d_c, sample_c);
            d_c = ~d_c;
            @(negedge clk);
        end
        ready_c = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
